// File: rtl/anim_seq_pkg.sv
// Shared types and constants for the animation sequencer.
// The hit states only exist when ANIM_SEQ_HIT_EN is defined.
package anim_seq_pkg;

    localparam int FRAME_SEL_END = 0;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        HOLD,
        END_DRAW,
        END_HOLD
`ifdef ANIM_SEQ_HIT_EN
        ,
        HIT_DRAW,
        HIT_HOLD
`endif
    } state_t;

endpackage

// File: rtl/anim_sequencer_if.sv
// Pixel-write bus from the sequencer to the frame-buffer writer.
interface anim_sequencer_if #(
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int ADDR_W = 16,
    parameter int SEL_W  = 3
);
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    logic              plot;
    logic [SEL_W-1:0]  frame_sel;

    modport master (output x, y, addr, plot, frame_sel);
    modport slave  (input  x, y, addr, plot, frame_sel);
endinterface

// File: rtl/raster_scan.sv
// Raster x/y/ROM-address counters; done flags the last pixel of the frame.
module raster_scan #(
    parameter int H_RES  = 320,
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int ADDR_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              load,
    input  logic [Y_W-1:0]    first_row,
    input  logic [Y_W-1:0]    last_row,
    input  logic              enable,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              row_end;

    assign row_end = (x_q == X_W'(H_RES - 1));
    assign done    = row_end && (y_q == last_row);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (load) begin
            x_d    = '0;
            y_d    = first_row;
            addr_d = '0;
        end else if (enable) begin
            x_d    = row_end ? '0 : x_q + 1'b1;
            y_d    = row_end ? y_q + 1'b1 : y_q;
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign addr = addr_q;
endmodule

// File: rtl/anim_sequencer.sv
// Frame animation sequencer: draw / hold loop with optional punch frame and end screen.
// Define ANIM_SEQ_HIT_EN to compile in the hit path (pending flag, hit states, hit_count).
module anim_sequencer
    import anim_seq_pkg::*;
#(
    parameter int NFRAMES  = 3,
    parameter int H_RES    = 320,
    parameter int Y_START  = 75,
    parameter int Y_END    = 240,
    parameter int END_Y0   = 10,
    parameter int END_Y1   = 230,
    parameter int HOLD_CYC = 100000000,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int ADDR_W   = 16,
    parameter int SEL_W    = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hit,
    input  logic                 game_over,
    anim_sequencer_if.master     pix,
    output logic                 busy,
    output logic [7:0]           hit_count
);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  frame_q, frame_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              load, enable, done, hold_done, drawing;
    logic [Y_W-1:0]    first_row, last_row;
    logic              pending_q;

    assign hold_done = (hold_cnt_q == HOLD_W'(HOLD_CYC - 1));

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        hold_cnt_d = '0;
        load       = 1'b0;
        first_row  = Y_W'(Y_START);
        case (state_q)
            IDLE: if (start) begin
                state_d = DRAW;
                frame_d = SEL_W'(1);
                load    = 1'b1;
            end
            DRAW:     if (done) state_d = HOLD;
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                // game_over wins over a pending punch
                if (game_over) begin
                    state_d   = END_DRAW;
                    first_row = Y_W'(END_Y0);
                    load      = 1'b1;
                end
`ifdef ANIM_SEQ_HIT_EN
                else if (pending_q) begin
                    state_d = HIT_DRAW;
                    load    = 1'b1;
                end
`endif
                else if (hold_done) begin
                    state_d = DRAW;
                    frame_d = (frame_q == SEL_W'(NFRAMES)) ? SEL_W'(1) : frame_q + 1'b1;
                    load    = 1'b1;
                end
            end
`ifdef ANIM_SEQ_HIT_EN
            HIT_DRAW: if (done) state_d = HIT_HOLD;
            HIT_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (game_over) begin
                    state_d   = END_DRAW;
                    first_row = Y_W'(END_Y0);
                    load      = 1'b1;
                end else if (hold_done) begin
                    state_d = DRAW;
                    frame_d = SEL_W'(1);
                    load    = 1'b1;
                end
            end
`endif
            END_DRAW: if (done) state_d = END_HOLD;
            END_HOLD: state_d = END_HOLD;
            default:  state_d = IDLE;
        endcase
        if (start && state_q != IDLE) begin
            state_d    = DRAW;
            frame_d    = SEL_W'(1);
            first_row  = Y_W'(Y_START);
            load       = 1'b1;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= IDLE;
            frame_q    <= SEL_W'(1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef ANIM_SEQ_HIT_EN
    logic       hit_prev_q, hit_prev_d, pending_d, hit_edge;
    logic [7:0] hit_count_q, hit_count_d;

    // A punch arriving together with start belongs to the old sequence and is dropped
    assign hit_edge = hit && !hit_prev_q && !start;

    always_comb begin
        hit_prev_d  = hit;
        pending_d   = pending_q;
        hit_count_d = hit_count_q;
        if (state_q == HOLD && !game_over && pending_q) pending_d = 1'b0;
        if (hit_edge) begin
            pending_d = 1'b1;
            if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 1'b1;
        end
        if (start) begin
            pending_d   = 1'b0;
            hit_count_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            hit_prev_q  <= 1'b0;
            pending_q   <= 1'b0;
            hit_count_q <= '0;
        end else begin
            hit_prev_q  <= hit_prev_d;
            pending_q   <= pending_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign hit_count = hit_count_q;
    assign drawing   = (state_q == DRAW) || (state_q == HIT_DRAW) || (state_q == END_DRAW);
`else
    logic unused_hit;
    assign unused_hit = hit;
    assign pending_q  = 1'b0;
    assign hit_count  = '0;
    assign drawing    = (state_q == DRAW) || (state_q == END_DRAW);
`endif

    assign enable   = drawing && !load;
    assign last_row = (state_q == END_DRAW) ? Y_W'(END_Y1 - 1) : Y_W'(Y_END - 1);

    raster_scan #(
        .H_RES  (H_RES),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .load      (load),
        .first_row (first_row),
        .last_row  (last_row),
        .enable    (enable),
        .x         (pix.x),
        .y         (pix.y),
        .addr      (pix.addr),
        .done      (done)
    );

    always_comb begin
        pix.frame_sel = frame_q;
        if (state_q == END_DRAW || state_q == END_HOLD) pix.frame_sel = SEL_W'(FRAME_SEL_END);
`ifdef ANIM_SEQ_HIT_EN
        if (state_q == HIT_DRAW || state_q == HIT_HOLD) pix.frame_sel = SEL_W'(NFRAMES + 1);
`endif
    end

    assign pix.plot = drawing;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with a 4x2 frame, 2 frames and a 5-cycle hold.
// Covers both builds; hit expectations depend on ANIM_SEQ_HIT_EN.
module tb_anim_sequencer;
    logic       CLOCK_50 = 1'b0;
    logic       reset, start, hit, game_over;
    logic       busy;
    logic [7:0] hit_count;
    int         errors = 0;
    int         checks = 0;
    logic [36:0] got, want;

`ifdef ANIM_SEQ_HIT_EN
    localparam logic [7:0] SAT_COUNT = 8'd255;
    localparam logic [7:0] GO_COUNT  = 8'd2;
`else
    localparam logic [7:0] SAT_COUNT = 8'd0;
    localparam logic [7:0] GO_COUNT  = 8'd0;
`endif

    anim_sequencer_if #(.X_W(9), .Y_W(8), .ADDR_W(16), .SEL_W(3)) pix ();

    anim_sequencer #(
        .NFRAMES(2), .H_RES(4), .Y_START(2), .Y_END(4), .END_Y0(0), .END_Y1(1),
        .HOLD_CYC(5), .X_W(9), .Y_W(8), .ADDR_W(16), .SEL_W(3)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .hit       (hit),
        .game_over (game_over),
        .pix       (pix),
        .busy      (busy),
        .hit_count (hit_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; hit = 1'b0; game_over = 1'b0;
        tick(3);
        checks++;
        if ({pix.plot, busy, pix.frame_sel, pix.x, pix.y, pix.addr, hit_count} !==
            {1'b0, 1'b0, 3'd1, 9'd0, 8'd0, 16'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: got plot=%0b busy=%0b sel=%0d x=%0d y=%0d addr=%0d cnt=%0d, want 0 0 1 0 0 0 0",
                     pix.plot, busy, pix.frame_sel, pix.x, pix.y, pix.addr, hit_count);
        end
    endtask

    task automatic test_first_frame();
        reset = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got  = {pix.plot, pix.x, pix.y, pix.addr, pix.frame_sel};
            want = {1'b1, 9'(i % 4), 8'(2 + i / 4), 16'(i), 3'd1};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL frame1_pixel[%0d]: got %h want %h", i, got, want);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({pix.plot, busy, pix.frame_sel} !== {1'b0, 1'b1, 3'd1}) begin
                errors++;
                $display("FAIL frame1_hold[%0d]: got plot=%0b busy=%0b sel=%0d want 0 1 1", i, pix.plot, busy, pix.frame_sel);
            end
            tick();
        end
        checks++;
        if ({pix.plot, pix.frame_sel, pix.x, pix.y, pix.addr} !== {1'b1, 3'd2, 9'd0, 8'd2, 16'd0}) begin
            errors++;
            $display("FAIL frame2_entry: got plot=%0b sel=%0d x=%0d y=%0d addr=%0d want 1 2 0 2 0",
                     pix.plot, pix.frame_sel, pix.x, pix.y, pix.addr);
        end
    endtask

    task automatic test_wrap();
        tick(8);
        checks++;
        if ({pix.plot, pix.frame_sel} !== {1'b0, 3'd2}) begin
            errors++;
            $display("FAIL frame2_hold: got plot=%0b sel=%0d want 0 2", pix.plot, pix.frame_sel);
        end
        tick(5);
        checks++;
        if ({pix.plot, pix.frame_sel, pix.addr} !== {1'b1, 3'd1, 16'd0}) begin
            errors++;
            $display("FAIL wrap_to_1: got plot=%0b sel=%0d addr=%0d want 1 1 0", pix.plot, pix.frame_sel, pix.addr);
        end
    endtask

    task automatic test_hit();
        tick(2);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick(5);
`ifdef ANIM_SEQ_HIT_EN
        checks++;
        if ({pix.plot, pix.frame_sel, hit_count} !== {1'b0, 3'd1, 8'd1}) begin
            errors++;
            $display("FAIL hit_hold_entry: got plot=%0b sel=%0d cnt=%0d want 0 1 1", pix.plot, pix.frame_sel, hit_count);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            got  = {pix.plot, pix.x, pix.y, pix.addr, pix.frame_sel};
            want = {1'b1, 9'(i % 4), 8'(2 + i / 4), 16'(i), 3'd3};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL hit_draw[%0d]: got %h want %h", i, got, want);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({pix.plot, pix.frame_sel} !== {1'b0, 3'd3}) begin
                errors++;
                $display("FAIL hit_hold[%0d]: got plot=%0b sel=%0d want 0 3", i, pix.plot, pix.frame_sel);
            end
            tick();
        end
        checks++;
        if ({pix.plot, pix.frame_sel, hit_count} !== {1'b1, 3'd1, 8'd1}) begin
            errors++;
            $display("FAIL hit_return: got plot=%0b sel=%0d cnt=%0d want 1 1 1", pix.plot, pix.frame_sel, hit_count);
        end
`else
        checks++;
        if ({pix.plot, pix.frame_sel, hit_count} !== {1'b0, 3'd1, 8'd0}) begin
            errors++;
            $display("FAIL hit_ignored_hold: got plot=%0b sel=%0d cnt=%0d want 0 1 0", pix.plot, pix.frame_sel, hit_count);
        end
        tick(5);
        checks++;
        if ({pix.plot, pix.frame_sel} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL hit_ignored_next: got plot=%0b sel=%0d want 1 2", pix.plot, pix.frame_sel);
        end
`endif
    endtask

    task automatic test_game_over();
        logic [2:0] cur;
        cur = pix.frame_sel;
        game_over = 1'b1; hit = 1'b1;
        tick();
        hit = 1'b0;
        tick(7);
        checks++;
        if ({pix.plot, pix.frame_sel} !== {1'b0, cur}) begin
            errors++;
            $display("FAIL go_hold_entry: got plot=%0b sel=%0d want 0 %0d", pix.plot, pix.frame_sel, cur);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            got  = {pix.plot, pix.x, pix.y, pix.addr, pix.frame_sel};
            want = {1'b1, 9'(i), 8'd0, 16'(i), 3'd0};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL end_draw[%0d]: got %h want %h", i, got, want);
            end
            tick();
        end
        game_over = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({pix.plot, busy, pix.frame_sel} !== {1'b0, 1'b1, 3'd0}) begin
                errors++;
                $display("FAIL end_hold[%0d]: got plot=%0b busy=%0b sel=%0d want 0 1 0", i, pix.plot, busy, pix.frame_sel);
            end
            tick();
        end
        checks++;
        if (hit_count !== GO_COUNT) begin
            errors++;
            $display("FAIL go_hit_count: got %0d want %0d", hit_count, GO_COUNT);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({pix.plot, pix.frame_sel, pix.y, pix.addr, hit_count} !== {1'b1, 3'd1, 8'd2, 16'd0, 8'd0}) begin
            errors++;
            $display("FAIL restart: got plot=%0b sel=%0d y=%0d addr=%0d cnt=%0d want 1 1 2 0 0",
                     pix.plot, pix.frame_sel, pix.y, pix.addr, hit_count);
        end
    endtask

    task automatic test_restart_clears_pending();
        tick(8);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({pix.plot, pix.frame_sel} !== {1'b0, 3'd1}) begin
                errors++;
                $display("FAIL clear_pending_hold[%0d]: got plot=%0b sel=%0d want 0 1", i, pix.plot, pix.frame_sel);
            end
            tick();
        end
        checks++;
        if ({pix.plot, pix.frame_sel} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL clear_pending_next: got plot=%0b sel=%0d want 1 2", pix.plot, pix.frame_sel);
        end
    endtask

    task automatic test_reset_mid_draw();
        tick(5);
        reset = 1'b0;
        tick();
        checks++;
        if ({pix.plot, busy, pix.frame_sel, pix.x, pix.addr} !== {1'b0, 1'b0, 3'd1, 9'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_mid_draw: got plot=%0b busy=%0b sel=%0d x=%0d addr=%0d want 0 0 1 0 0",
                     pix.plot, busy, pix.frame_sel, pix.x, pix.addr);
        end
        reset = 1'b1;
        tick(2);
        checks++;
        if ({pix.plot, busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got plot=%0b busy=%0b want 0 0", pix.plot, busy);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            tick();
        end
        checks++;
        if (hit_count !== SAT_COUNT) begin
            errors++;
            $display("FAIL hit_saturate: got %0d want %0d", hit_count, SAT_COUNT);
        end
        // punch coincident with start must be dropped
        start = 1'b1; hit = 1'b1;
        tick();
        start = 1'b0; hit = 1'b0;
        checks++;
        if ({pix.plot, pix.frame_sel, hit_count} !== {1'b1, 3'd1, 8'd0}) begin
            errors++;
            $display("FAIL start_with_hit: got plot=%0b sel=%0d cnt=%0d want 1 1 0", pix.plot, pix.frame_sel, hit_count);
        end
        tick(13);
        checks++;
        if ({pix.plot, pix.frame_sel, hit_count} !== {1'b1, 3'd2, 8'd0}) begin
            errors++;
            $display("FAIL start_with_hit_next: got plot=%0b sel=%0d cnt=%0d want 1 2 0", pix.plot, pix.frame_sel, hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_wrap();
        test_hit();
        test_game_over();
        test_restart_clears_pending();
        test_reset_mid_draw();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
